// File: rtl/mag_tape_seq_if.sv
// Tape sequencer control bundle: command/status inputs from tape decode and the
// motor/head drive outputs. The master side is the tape controller.
interface mag_tape_seq_if;
    logic TICK;
    logic MAG_TAPE_FWD;
    logic MAG_TAPE_REV;
    logic MAG6_OUT;
    logic TAPE_READY;
    logic TAPE_EOT;
    logic TAPE_BOT;
    logic BLOCK_MARK;
    logic DRIVE_FWD;
    logic DRIVE_REV;
    logic DRIVE_WRITE;
    logic HEAD_VALID;
    logic BUSY;
    logic CMD_DONE;
    logic FAULT;

    modport master (
        output TICK, MAG_TAPE_FWD, MAG_TAPE_REV, MAG6_OUT,
        output TAPE_READY, TAPE_EOT, TAPE_BOT, BLOCK_MARK,
        input  DRIVE_FWD, DRIVE_REV, DRIVE_WRITE, HEAD_VALID,
        input  BUSY, CMD_DONE, FAULT
    );

    modport slave (
        input  TICK, MAG_TAPE_FWD, MAG_TAPE_REV, MAG6_OUT,
        input  TAPE_READY, TAPE_EOT, TAPE_BOT, BLOCK_MARK,
        output DRIVE_FWD, DRIVE_REV, DRIVE_WRITE, HEAD_VALID,
        output BUSY, CMD_DONE, FAULT
    );
endinterface

// File: rtl/mag_tape_seq.sv
// Magnetic tape motion sequencer: accelerate, run to block mark or tape marker,
// decelerate, with run timeout and drive-offline fault. Fault is sticky until reset.
module mag_tape_seq #(
    parameter int unsigned ACCEL_TICKS   = 16,
    parameter int unsigned DECEL_TICKS   = 12,
    parameter int unsigned TIMEOUT_TICKS = 4095
) (
    input logic           CLK,
    input logic           rst_n,
    mag_tape_seq_if.slave bus
);
    localparam int unsigned CNT_W = 12;
    localparam logic [CNT_W-1:0] ACCEL_LAST   = CNT_W'(ACCEL_TICKS - 1);
    localparam logic [CNT_W-1:0] DECEL_LAST   = CNT_W'(DECEL_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCEL = 3'd1,
        S_RUN   = 3'd2,
        S_DECEL = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_rev_q, dir_rev_d;
    logic             write_q, write_d;
    logic             done_c;
    logic             moving_c;
    logic             at_marker_c;

    // A tape marker only stops motion heading toward it.
    assign at_marker_c = dir_rev_q ? bus.TAPE_BOT : bus.TAPE_EOT;

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_rev_d = dir_rev_q;
        write_d   = write_q;
        done_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.MAG_TAPE_FWD && bus.MAG_TAPE_REV) begin
                    state_d = S_FAULT;
                end else if (bus.MAG_TAPE_FWD) begin
                    if (bus.TAPE_EOT) begin
                        done_c = 1'b1;
                    end else if (bus.TAPE_READY) begin
                        state_d   = S_ACCEL;
                        cnt_d     = '0;
                        dir_rev_d = 1'b0;
                        write_d   = bus.MAG6_OUT;
                    end
                end else if (bus.MAG_TAPE_REV) begin
                    if (bus.TAPE_BOT) begin
                        done_c = 1'b1;
                    end else if (bus.TAPE_READY) begin
                        state_d   = S_ACCEL;
                        cnt_d     = '0;
                        dir_rev_d = 1'b1;
                        write_d   = 1'b0;
                    end
                end
            end
            S_ACCEL: begin
                if (!bus.TAPE_READY) begin
                    state_d = S_FAULT;
                end else if (bus.TICK) begin
                    if (cnt_q == ACCEL_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!bus.TAPE_READY) begin
                    state_d = S_FAULT;
                end else if (bus.BLOCK_MARK || at_marker_c) begin
                    state_d = S_DECEL;
                    cnt_d   = '0;
                end else if (bus.TICK) begin
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DECEL: begin
                if (!bus.TAPE_READY) begin
                    state_d = S_FAULT;
                end else if (bus.TICK) begin
                    if (cnt_q == DECEL_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_c  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign moving_c = (state_d == S_ACCEL) || (state_d == S_RUN);

    // State register; outputs are registered from the next state so they track it.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            dir_rev_q       <= 1'b0;
            write_q         <= 1'b0;
            bus.DRIVE_FWD   <= 1'b0;
            bus.DRIVE_REV   <= 1'b0;
            bus.DRIVE_WRITE <= 1'b0;
            bus.HEAD_VALID  <= 1'b0;
            bus.BUSY        <= 1'b0;
            bus.CMD_DONE    <= 1'b0;
            bus.FAULT       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dir_rev_q       <= dir_rev_d;
            write_q         <= write_d;
            bus.DRIVE_FWD   <= moving_c && !dir_rev_d;
            bus.DRIVE_REV   <= moving_c && dir_rev_d;
            bus.DRIVE_WRITE <= (state_d == S_RUN) && write_d;
            bus.HEAD_VALID  <= (state_d == S_RUN);
            bus.BUSY        <= (state_d != S_IDLE);
            bus.CMD_DONE    <= done_c;
            bus.FAULT       <= (state_d == S_FAULT);
        end
    end
endmodule
